// File: rtl/snapshot_mem_responder.sv
// Single-request memory responder: turns a held mem_req_vld handshake into one
// SRAM access with fixed read latency, grant stalls, abort and timeout handling.
//
// state   | meaning
// IDLE    | waiting for a request; latches addr/wdata/op on acceptance
// ISSUE   | driving the SRAM port until sram_rdy grants (or abort/timeout)
// RD_WAIT | counting down read latency, then capturing sram_rdata
// ACK     | one-cycle mem_ack_vld pulse
// DONE    | waiting for the initiator to drop mem_req_vld
module snapshot_mem_responder #(
  parameter int MEM_WIDTH      = 36,
  parameter int ENTRY_WIDTH    = 7,
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mst__fsm__sync_reset,
  input  logic                   mem_req_vld,
  input  logic [ENTRY_WIDTH-1:0] mem_addr,
  input  logic                   mem_rd_en,
  input  logic                   mem_wr_en,
  input  logic [MEM_WIDTH-1:0]   mem_wr_data,
  output logic [MEM_WIDTH-1:0]   mem_rd_data,
  output logic                   mem_ack_vld,
  output logic                   sram_cs,
  output logic                   sram_we,
  output logic [ENTRY_WIDTH-1:0] sram_addr,
  output logic [MEM_WIDTH-1:0]   sram_wdata,
  input  logic [MEM_WIDTH-1:0]   sram_rdata,
  input  logic                   sram_rdy,
  output logic                   err_timeout
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX   = {TO_W{1'b1}};
  localparam logic [2:0]      LAT_INIT = 3'(RD_LATENCY - 1);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    ISSUE   = 5'b00010,
    RD_WAIT = 5'b00100,
    ACK     = 5'b01000,
    DONE    = 5'b10000
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             lat_cnt_q, lat_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [ENTRY_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
  logic                   op_wr_q, op_wr_d;
  logic [MEM_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   cs_q, cs_d;
  logic                   we_q, we_d;
  logic [ENTRY_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [MEM_WIDTH-1:0]   sram_wdata_q, sram_wdata_d;

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    to_cnt_d  = to_cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_wr_d   = op_wr_q;
    rd_data_d = rd_data_q;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_req_vld) begin
          addr_d   = mem_addr;
          wdata_d  = mem_wr_data;
          op_wr_d  = mem_wr_en;
          to_cnt_d = '0;
          state_d  = (mem_wr_en || mem_rd_en) ? ISSUE : ACK;
        end
      end
      ISSUE: begin
        // abort wins over grant and timeout: the initiator has withdrawn
        if (!mem_req_vld) begin
          state_d  = IDLE;
          to_cnt_d = '0;
        end else if (sram_rdy) begin
          to_cnt_d = '0;
          if (op_wr_q) begin
            state_d = ACK;
          end else begin
            state_d   = RD_WAIT;
            lat_cnt_d = LAT_INIT;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST)) begin
          err_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = ACK;
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      RD_WAIT: begin
        if (lat_cnt_q == 3'd0) begin
          rd_data_d = sram_rdata;
          state_d   = ACK;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      ACK:  state_d = DONE;
      DONE: if (!mem_req_vld) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (mst__fsm__sync_reset) begin
      state_d   = IDLE;
      lat_cnt_d = '0;
      to_cnt_d  = '0;
      err_d     = 1'b0;
      rd_data_d = rd_data_q;
    end

    // outputs are registered from the next state so they align with it
    ack_d        = (state_d == ACK);
    cs_d         = (state_d == ISSUE);
    we_d         = cs_d && op_wr_d;
    sram_addr_d  = cs_d ? addr_d : '0;
    sram_wdata_d = cs_d ? wdata_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      to_cnt_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_wr_q      <= 1'b0;
      rd_data_q    <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      to_cnt_q     <= to_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_wr_q      <= op_wr_d;
      rd_data_q    <= rd_data_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign mem_rd_data = rd_data_q;
  assign mem_ack_vld = ack_q;
  assign err_timeout = err_q;
  assign sram_cs     = cs_q;
  assign sram_we     = we_q;
  assign sram_addr   = sram_addr_q;
  assign sram_wdata  = sram_wdata_q;

endmodule

// File: tb/tb_snapshot_mem_responder.sv
// Bench for snapshot_mem_responder: bench-owned SRAM model plus a transaction-level
// latency/data model, checked every cycle on the falling edge.
module tb_snapshot_mem_responder;

  localparam int MW     = 36;
  localparam int AW     = 7;
  localparam int RD_LAT = 2;
  localparam int TO     = 4;

  logic          clk = 1'b0;
  logic          rst, mst__fsm__sync_reset, mem_req_vld, mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wr_data, mem_rd_data, sram_wdata, sram_rdata;
  logic          mem_ack_vld, sram_cs, sram_we, sram_rdy, err_timeout;
  logic [AW-1:0] sram_addr;

  snapshot_mem_responder #(
    .MEM_WIDTH(MW), .ENTRY_WIDTH(AW), .RD_LATENCY(RD_LAT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .mst__fsm__sync_reset(mst__fsm__sync_reset),
    .mem_req_vld(mem_req_vld), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_ack_vld(mem_ack_vld), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_rdy(sram_rdy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [MW-1:0] mem_model [128];
  int            pend_cnt;
  logic [MW-1:0] pend_data;

  // current transaction and its expectations
  logic [AW-1:0] cur_addr;
  logic [MW-1:0] cur_wdata;
  logic          cur_wr;
  int            stalls, issue_seen, txn_t, exp_ack_cyc, exp_cs_n;
  logic          exp_to, exp_rd_upd, cs_ok;
  logic [MW-1:0] exp_rd_val, exp_rd_data;
  int            meas_ack, meas_cs, meas_err, ack_at;

  function automatic logic [MW-1:0] rand36();
    return {4'($urandom), $urandom};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic scramble();
    mem_addr    = 7'($urandom);
    mem_wr_data = rand36();
    mem_wr_en   = 1'($urandom_range(0, 1));
    mem_rd_en   = 1'($urandom_range(0, 1));
  endtask

  // One cycle: SRAM model, per-cycle output comparison, grant decision.
  task automatic tick();
    logic hit;
    @(negedge clk);
    cyc++;
    hit = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      hit = (pend_cnt == 0);
    end
    sram_rdata = hit ? pend_data : rand36();
    if (cyc == exp_ack_cyc && exp_rd_upd) exp_rd_data = exp_rd_val;

    check("ack", 64'(mem_ack_vld), 64'(cyc == exp_ack_cyc));
    check("err_timeout", 64'(err_timeout), 64'((cyc == exp_ack_cyc) && exp_to));
    check("rd_data", 64'(mem_rd_data), 64'(exp_rd_data));
    if (!cs_ok) check("cs_unexpected", 64'(sram_cs), 64'd0);
    if (sram_cs) begin
      check("sram_addr", 64'(sram_addr), 64'(cur_addr));
      check("sram_we", 64'(sram_we), 64'(cur_wr));
      check("sram_wdata", 64'(sram_wdata), 64'(cur_wdata));
    end else begin
      check("sram_quiet", 64'({sram_we, sram_addr, sram_wdata}), 64'd0);
    end

    if (mem_ack_vld) begin
      meas_ack++;
      ack_at = cyc;
    end
    if (err_timeout) meas_err++;
    if (sram_cs) begin
      meas_cs++;
      sram_rdy = (issue_seen >= stalls);
      issue_seen++;
      if (sram_rdy) begin
        if (sram_we) mem_model[sram_addr] = sram_wdata;
        else begin
          pend_cnt  = RD_LAT;
          pend_data = mem_model[sram_addr];
        end
      end
    end else begin
      sram_rdy = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic begin_txn(input logic [1:0] kind, input logic [AW-1:0] a,
                           input logic [MW-1:0] d, input int st);
    tick();
    mem_req_vld = 1'b1;
    mem_addr    = a;
    mem_wr_data = d;
    mem_wr_en   = kind[1];
    mem_rd_en   = kind[0];
    txn_t       = cyc;
    cur_addr    = a;
    cur_wdata   = d;
    cur_wr      = kind[1];
    stalls      = st;
    issue_seen  = 0;
    meas_ack    = 0;
    meas_cs     = 0;
    meas_err    = 0;
    ack_at      = -1;
    exp_ack_cyc = -1;
    exp_to      = 1'b0;
    exp_rd_upd  = 1'b0;
    cs_ok       = (kind != 2'b00);
  endtask

  // kind: 0 null, 1 read, 2 write, 3 both enables (write wins)
  task automatic run_txn(input logic [1:0] kind, input logic [AW-1:0] a,
                         input logic [MW-1:0] d, input int st, input int hold);
    int   lat;
    logic is_wr, is_rd;
    begin_txn(kind, a, d, st);
    is_wr  = kind[1];
    is_rd  = !kind[1] && kind[0];
    exp_to = (is_wr || is_rd) && (TO != 0) && (st >= TO);
    if (!(is_wr || is_rd)) begin
      lat = 1;
      exp_cs_n = 0;
    end else if (exp_to) begin
      lat = 1 + TO;
      exp_cs_n = TO;
    end else begin
      lat = is_wr ? 2 + st : 2 + RD_LAT + st;
      exp_cs_n = st + 1;
    end
    exp_rd_upd  = is_rd && !exp_to;
    exp_rd_val  = mem_model[a];
    exp_ack_cyc = txn_t + lat;
    for (int i = 0; i < lat; i++) begin
      tick();
      scramble();
    end
    cs_ok = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      scramble();
    end
    tick();
    mem_req_vld = 1'b0;
    scramble();
    check("ack_count", 64'(meas_ack), 64'd1);
    check("cs_cycles", 64'(meas_cs), 64'(exp_cs_n));
    check("err_count", 64'(meas_err), 64'(exp_to));
  endtask

  logic [MW-1:0] saved;

  initial begin
    rst = 1'b1;
    mst__fsm__sync_reset = 1'b0;
    mem_req_vld = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr = '0;
    mem_wr_data = '0;
    sram_rdata = '0;
    sram_rdy = 1'b0;
    pend_cnt = 0;
    pend_data = '0;
    exp_ack_cyc = -1;
    exp_rd_data = '0;
    exp_rd_upd = 1'b0;
    exp_to = 1'b0;
    cs_ok = 1'b0;
    cur_addr = '0;
    cur_wdata = '0;
    cur_wr = 1'b0;
    stalls = 0;
    issue_seen = 0;
    for (int i = 0; i < 128; i++) mem_model[i] = rand36();

    repeat (3) tick();
    rst = 1'b0;
    check("reset_rd_data", 64'(mem_rd_data), 64'd0);
    check("reset_ack", 64'(mem_ack_vld), 64'd0);
    check("reset_cs", 64'(sram_cs), 64'd0);
    tick();

    // read, RD_LATENCY=2, immediate grant
    mem_model[5] = 36'hA_BCDE_1234;
    run_txn(2'b01, 7'h05, rand36(), 0, 0);
    check("rd_latency_lit", 64'(ack_at - txn_t), 64'd4);
    check("rd_data_lit", 64'(mem_rd_data), 64'hA_BCDE_1234);
    check("rd_cs_lit", 64'(meas_cs), 64'd1);

    // write with three stall cycles
    run_txn(2'b10, 7'h7F, 36'h9_0000_0001, 3, 1);
    check("wr_latency_lit", 64'(ack_at - txn_t), 64'd5);
    check("wr_cs_lit", 64'(meas_cs), 64'd4);
    check("wr_mem_lit", 64'(mem_model[7'h7F]), 64'h9_0000_0001);
    check("wr_err_lit", 64'(meas_err), 64'd0);

    // null request
    run_txn(2'b00, 7'h12, rand36(), 0, 0);
    check("null_latency_lit", 64'(ack_at - txn_t), 64'd1);
    check("null_rd_data_lit", 64'(mem_rd_data), 64'hA_BCDE_1234);

    // timeout on a read
    run_txn(2'b01, 7'h20, rand36(), 100, 0);
    check("to_latency_lit", 64'(ack_at - txn_t), 64'd5);
    check("to_err_lit", 64'(meas_err), 64'd1);
    check("to_rd_data_lit", 64'(mem_rd_data), 64'hA_BCDE_1234);

    // abort: drop request in the second stalled ISSUE cycle
    saved = mem_model[7'h33];
    begin_txn(2'b10, 7'h33, 36'h1_2345_6789, 10);
    for (int i = 0; i < 8 && issue_seen < 2; i++) tick();
    check("abort_reached", 64'(issue_seen), 64'd2);
    mem_req_vld = 1'b0;
    cs_ok = 1'b0;
    repeat (3) tick();
    check("abort_ack", 64'(meas_ack), 64'd0);
    check("abort_cs", 64'(meas_cs), 64'd2);
    check("abort_mem", 64'(mem_model[7'h33]), 64'(saved));
    run_txn(2'b01, 7'h05, rand36(), 1, 0);
    check("post_abort_data", 64'(mem_rd_data), 64'hA_BCDE_1234);

    // FSM flush while waiting for read data
    begin_txn(2'b01, 7'h40, rand36(), 0);
    tick();
    tick();
    mst__fsm__sync_reset = 1'b1;
    mem_req_vld = 1'b0;
    cs_ok = 1'b0;
    tick();
    mst__fsm__sync_reset = 1'b0;
    repeat (3) tick();
    check("flush_ack", 64'(meas_ack), 64'd0);
    check("flush_cs", 64'(meas_cs), 64'd1);
    run_txn(2'b01, 7'h41, rand36(), 0, 0);
    check("post_flush_latency", 64'(ack_at - txn_t), 64'd4);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 9);
      run_txn(2'($urandom_range(0, 3)), 7'($urandom), rand36(),
              (r < 7) ? (r % 4) : 4 + $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // reset in the middle of a stalled write
    saved = mem_model[7'h11];
    begin_txn(2'b10, 7'h11, rand36(), 3);
    tick();
    tick();
    rst = 1'b1;
    mem_req_vld = 1'b0;
    cs_ok = 1'b0;
    exp_rd_data = '0;
    tick();
    check("rst_rd_data", 64'(mem_rd_data), 64'd0);
    check("rst_outputs", 64'({mem_ack_vld, err_timeout, sram_cs, sram_we, sram_addr, sram_wdata}), 64'd0);
    rst = 1'b0;
    repeat (2) tick();
    check("rst_mem", 64'(mem_model[7'h11]), 64'(saved));
    run_txn(2'b01, 7'h11, rand36(), 0, 0);
    check("post_rst_data", 64'(mem_rd_data), 64'(saved));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/snapshot_mem_responder.md
# snapshot_mem_responder

Memory-side responder for the snapshot register front-end's downstream port. It accepts one request at a time on the mem_req_vld/mem_ack_vld handshake and converts it into a single-port SRAM access with a fixed read latency and a shared-port ready. It returns read data and a one-cycle acknowledge. It sits between a snapshot register block and its backing SRAM (or SRAM arbiter).

## Interface
- MEM_WIDTH, 36, entry width in bits (mem_wr_data, mem_rd_data, sram data).
- ENTRY_WIDTH, 7, entry address width.
- RD_LATENCY, 1, SRAM read latency in cycles from accepted issue to sram_rdata valid; legal 1..8.
- TIMEOUT_CYCLES, 16, maximum ISSUE cycles with sram_rdy low before giving up; 0 disables the timeout.
- clk  input  1  clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- mst__fsm__sync_reset  input  1  synchronous FSM flush.
- mem_req_vld  input  1  request valid; held high by the initiator until it observes the ack.
- mem_addr  input  ENTRY_WIDTH  entry address; sampled when a request is accepted.
- mem_rd_en  input  1  read request; sampled when a request is accepted.
- mem_wr_en  input  1  write request; sampled when a request is accepted.
- mem_wr_data  input  MEM_WIDTH  write data; sampled when a request is accepted.
- mem_rd_data  output  MEM_WIDTH  registered read data; holds the last captured value.
- mem_ack_vld  output  1  one-cycle completion pulse.
- sram_cs  output  1  SRAM chip select.
- sram_we  output  1  SRAM write enable.
- sram_addr  output  ENTRY_WIDTH  SRAM address.
- sram_wdata  output  MEM_WIDTH  SRAM write data.
- sram_rdata  input  MEM_WIDTH  SRAM read data.
- sram_rdy  input  1  SRAM port grant; an issue cycle counts only when this is high.
- err_timeout  output  1  one-cycle pulse when a request is abandoned on timeout.

## Operation
States are one-hot: IDLE, ISSUE, RD_WAIT, ACK, DONE.
- **IDLE**
  - On mem_req_vld=1, latch addr, wdata and op.
  - op=WR if mem_wr_en; otherwise op=RD if mem_rd_en. Write has priority when both are high.
  - If either enable is high, go to ISSUE. If neither is high (null request: invalid entry or protected write), go to ACK with no SRAM access.
- **ISSUE**
  - Drive sram_cs=1, sram_we=(op==WR), sram_addr and sram_wdata from the latches.
  - If sram_rdy=1: a write goes to ACK; a read goes to RD_WAIT with lat_cnt=RD_LATENCY-1.
  - If sram_rdy=0: stay in ISSUE and increment to_cnt.
  - If mem_req_vld drops while in ISSUE: go to IDLE with no ack and no access (abort).
  - If TIMEOUT_CYCLES!=0 and to_cnt reaches TIMEOUT_CYCLES-1 with sram_rdy=0: pulse err_timeout and go to ACK. mem_rd_data is unchanged.
- **RD_WAIT**
  - sram_cs=0. Decrement lat_cnt.
  - When lat_cnt==0, capture sram_rdata into mem_rd_data and go to ACK.
  - mem_req_vld is ignored here; the access always completes.
- **ACK**
  - mem_ack_vld=1 for exactly one cycle, then go to DONE.
- **DONE**
  - Stay until mem_req_vld==0, then go to IDLE. This prevents re-accepting a request the initiator still holds while it registers the ack.
  - If mem_req_vld is already 0, leave after one cycle.
- **Resets**
  - mst__fsm__sync_reset: next state IDLE; counters cleared; pending ack and timeout pulses suppressed. mem_rd_data is not cleared.
  - rst: overrides everything.
- **Outputs**
  - sram_* outputs are 0 in every state except ISSUE.
  - sram_addr and sram_wdata come only from the latches, never directly from the mem_* inputs.
- **Counters**
  - lat_cnt width is clog2(8)=3.
  - to_cnt width is clog2(TIMEOUT_CYCLES) with a minimum of 1; it saturates, never wraps.

## Timing
- **Reset values** (after rst): state IDLE; mem_rd_data=0; mem_ack_vld=0; err_timeout=0; sram_cs=0; sram_we=0; sram_addr=0; sram_wdata=0; counters 0.
- **Latency from request in cycle T (IDLE), sram_rdy high:**
  - Write: ISSUE at T+1, ack at T+2.
  - Read: ISSUE at T+1, capture at T+1+RD_LATENCY, ack at T+2+RD_LATENCY.
  - Null: ack at T+1.
- **sram_rdy low:** each cycle of sram_rdy=0 in ISSUE adds one cycle to the latency.
- **mem_rd_data:** updates on the same edge that enters ACK, so it is valid while mem_ack_vld=1 and stays stable afterwards.
- **Throughput:** at most one request per ACK→DONE→IDLE cycle. Back-to-back requests separated by one low cycle of mem_req_vld are both served.

## Test plan
- Read, RD_LATENCY=2, sram_rdy=1, addr 0x05, SRAM returns 0xA_BCDE_1234 → sram_cs high one cycle at T+1 with addr 0x05 and we=0. mem_ack_vld at T+4 with mem_rd_data=0xA_BCDE_1234. Exactly one ack pulse.
- Write of 0x9_0000_0001 to addr 0x7F with sram_rdy low 3 cycles → sram_cs held 4 cycles with we=1. Ack at T+5. No err_timeout.
- Null request (rd_en=wr_en=0) → ack at T+1. No sram_cs. mem_rd_data keeps its previous value.
- TIMEOUT_CYCLES=4, sram_rdy stuck 0 on a read → err_timeout pulse after 4 ISSUE cycles, then ack. mem_rd_data unchanged.
- mem_req_vld dropped in the 2nd ISSUE cycle (sram_rdy=0) → return to IDLE, no ack, no SRAM write. The next request is served normally.
- mst__fsm__sync_reset asserted in RD_WAIT → IDLE next cycle, no ack. rst mid-write → all outputs at their reset values the next cycle.
